// File: rtl/memory_32_7_arbiter_if.sv
// Bundle of the two requester ports, the shared read-return data and the
// memory_32_7 wrapper drive signals seen by the arbiter.
interface memory_32_7_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req0_vld;
    logic              req0_wr;
    logic [ADDR_W-1:0] req0_address;
    logic [DATA_W-1:0] req0_wr_data;
    logic              req0_rdy;
    logic              req0_rd_data_vld;

    logic              req1_vld;
    logic              req1_wr;
    logic [ADDR_W-1:0] req1_address;
    logic [DATA_W-1:0] req1_wr_data;
    logic              req1_rdy;
    logic              req1_rd_data_vld;

    logic [DATA_W-1:0] rd_data;

    logic              m_wr_vld;
    logic [ADDR_W-1:0] m_wr_address;
    logic [DATA_W-1:0] m_wr_data;
    logic [ADDR_W-1:0] m_rd_address;
    logic [DATA_W-1:0] m_rd_data;

    // arbiter side
    modport slave (
        input  req0_vld, req0_wr, req0_address, req0_wr_data,
        output req0_rdy, req0_rd_data_vld,
        input  req1_vld, req1_wr, req1_address, req1_wr_data,
        output req1_rdy, req1_rd_data_vld,
        output rd_data,
        output m_wr_vld, m_wr_address, m_wr_data, m_rd_address,
        input  m_rd_data
    );

    // requesters plus memory side, as seen from outside the arbiter
    modport master (
        output req0_vld, req0_wr, req0_address, req0_wr_data,
        input  req0_rdy, req0_rd_data_vld,
        output req1_vld, req1_wr, req1_address, req1_wr_data,
        input  req1_rdy, req1_rd_data_vld,
        input  rd_data,
        input  m_wr_vld, m_wr_address, m_wr_data, m_rd_address,
        output m_rd_data
    );
endinterface

// File: rtl/memory_32_7_arbiter.sv
// Two-requester arbiter in front of one memory_32_7 (1W + 1R per cycle,
// 2-cycle read latency). Writes and reads are arbitrated independently,
// each round-robin on contested cycles only. A {vld, id} shift register
// as deep as the read latency steers the returning data to its issuer.
module memory_32_7_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    memory_32_7_arbiter_if.slave   bus
);

    logic wr_cand0, wr_cand1;
    logic rd_cand0, rd_cand1;
    logic wr_gnt0, wr_gnt1;
    logic rd_gnt0, rd_gnt1;

    // 1 = requester 1 won the last contested grant, so requester 0 wins next
    logic wr_last;
    logic rd_last;

    // index 0 is loaded from the read grant, index RD_LAT-1 lines up with m_rd_data
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_id;

    logic [ADDR_W-1:0] wr_address_sel;
    logic [DATA_W-1:0] wr_data_sel;
    logic [ADDR_W-1:0] rd_address_sel;

    // candidate qualification and round-robin grant; nothing is granted in reset
    always_comb begin
        wr_cand0 = bus.req0_vld &  bus.req0_wr & ~reset;
        wr_cand1 = bus.req1_vld &  bus.req1_wr & ~reset;
        rd_cand0 = bus.req0_vld & ~bus.req0_wr & ~reset;
        rd_cand1 = bus.req1_vld & ~bus.req1_wr & ~reset;

        wr_gnt0  = wr_cand0 & (~wr_cand1 |  wr_last);
        wr_gnt1  = wr_cand1 & (~wr_cand0 | ~wr_last);
        rd_gnt0  = rd_cand0 & (~rd_cand1 |  rd_last);
        rd_gnt1  = rd_cand1 & (~rd_cand0 | ~rd_last);
    end

    // steer the grantees' address/data onto the memory ports, zero when idle
    always_comb begin
        wr_address_sel = '0;
        wr_data_sel    = '0;
        rd_address_sel = '0;
        if (wr_gnt0) begin
            wr_address_sel = bus.req0_address;
            wr_data_sel    = bus.req0_wr_data;
        end else if (wr_gnt1) begin
            wr_address_sel = bus.req1_address;
            wr_data_sel    = bus.req1_wr_data;
        end
        if (rd_gnt0) begin
            rd_address_sel = bus.req0_address;
        end else if (rd_gnt1) begin
            rd_address_sel = bus.req1_address;
        end
    end

    assign bus.m_wr_vld     = wr_gnt0 | wr_gnt1;
    assign bus.m_wr_address = wr_address_sel;
    assign bus.m_wr_data    = wr_data_sel;
    assign bus.m_rd_address = rd_address_sel;

    // a requester carries one command per cycle, so either grant accepts it
    assign bus.req0_rdy = wr_gnt0 | rd_gnt0;
    assign bus.req1_rdy = wr_gnt1 | rd_gnt1;

    assign bus.req0_rd_data_vld = pipe_vld[RD_LAT-1] & ~pipe_id[RD_LAT-1];
    assign bus.req1_rd_data_vld = pipe_vld[RD_LAT-1] &  pipe_id[RD_LAT-1];
    assign bus.rd_data          = bus.m_rd_data;

    // round-robin state only moves when both requesters competed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_last <= 1'b1;
            rd_last <= 1'b1;
        end else begin
            if (wr_cand0 && wr_cand1) begin
                wr_last <= wr_gnt1;
            end
            if (rd_cand0 && rd_cand1) begin
                rd_last <= rd_gnt1;
            end
        end
    end

    // in-flight read tracker; reset drops everything still in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= rd_gnt0 | rd_gnt1;
            pipe_id[0]  <= rd_gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

endmodule
